// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the pipelined increment/decrement adder.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package arith_pkg;

  // Mode encoding carried with each beat.
  localparam logic MODE_INC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  // Pipeline depth: one stage per SEG_W-bit segment, rounded up.
  function automatic int stages_f(input int n, input int seg_w);
    return (n + seg_w - 1) / seg_w;
  endfunction

endpackage

// File: rtl/pipelined_one_adder_if.sv
// Streaming bus for the pipelined adder: input beat {A,cin,dec,sat} and result beat {SUM,cout}.
// Latency: n/a (wires only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the result side.
// master = producer of operands / consumer of results; slave = the adder.
interface pipelined_one_adder_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic         cin;
  logic         dec;
  logic         sat;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] SUM;
  logic         cout;

  modport master (
    output in_valid, A, cin, dec, sat, out_ready,
    input  in_ready, out_valid, SUM, cout
  );

  modport slave (
    input  in_valid, A, cin, dec, sat, out_ready,
    output in_ready, out_valid, SUM, cout
  );
endinterface

// File: rtl/one_adder_seg.sv
// Combinational W-bit segment increment/decrement by a single carry/borrow bit.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; sits inside a pipeline stage.
// Ports: seg/c_in/dec in, seg_out/c_out out (c_out is carry in inc mode, borrow in dec mode).
module one_adder_seg
  import arith_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] seg,
  input  logic         c_in,
  input  logic         dec,
  output logic [W-1:0] seg_out,
  output logic         c_out
);

  logic [W:0] inc_sum;

  assign inc_sum = {1'b0, seg} + (W+1)'(c_in);

  // Subtracting one borrows out only when the segment is already zero.
  assign seg_out = (dec == MODE_DEC) ? (seg - W'(c_in)) : inc_sum[W-1:0];
  assign c_out   = (dec == MODE_DEC) ? ((seg == '0) && c_in) : inc_sum[W];

endmodule

// File: rtl/pipelined_one_adder.sv
// Pipelined N-bit A+cin / A-cin with optional saturation, one SEG_W-bit segment per stage.
// Latency: STAGES = ceil(N/SEG_W) cycles, 1 beat/cycle throughput.
// Backpressure: full; in_ready is combinational from out_ready through the stage chain.
// Ports: clk, reset (sync, active-high), bus (slave side of pipelined_one_adder_if).
module pipelined_one_adder
  import arith_pkg::*;
#(
  parameter int N     = 32,
  parameter int SEG_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  pipelined_one_adder_if.slave  bus
);

  localparam int STAGES = stages_f(N, SEG_W);
  localparam int LAST   = STAGES - 1;

  // Per-stage state: valid, partial result, carry into the next segment, mode flags.
  logic [STAGES-1:0] vld_q;
  logic [N-1:0]      res_q [STAGES];
  logic [STAGES-1:0] cy_q;
  logic [STAGES-1:0] dec_q;
  logic [STAGES-1:0] sat_q;

  logic [N-1:0]      res_d [STAGES];
  logic [STAGES-1:0] cy_d;
  logic [STAGES-1:0] dec_d;
  logic [STAGES-1:0] sat_d;

  logic [STAGES-1:0] adv;   // stage content moves downstream this cycle
  logic [STAGES-1:0] load;  // stage captures a new beat this cycle
  logic              in_ready_w;

  assign in_ready_w   = !reset && (!vld_q[0] || adv[0]);
  assign bus.in_ready = in_ready_w;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG_W;
    localparam int HI = ((k + 1) * SEG_W < N) ? ((k + 1) * SEG_W - 1) : (N - 1);
    localparam int W  = HI - LO + 1;

    logic [N-1:0] src_res;
    logic         src_cy;
    logic         src_dec;
    logic         src_sat;
    logic [W-1:0] seg_out;
    logic         c_out;
    logic [N-1:0] nxt;

    if (k == 0) begin : g_first
      assign src_res = bus.A;
      assign src_cy  = bus.cin;
      assign src_dec = bus.dec;
      assign src_sat = bus.sat;
      assign load[k] = bus.in_valid && in_ready_w;
    end else begin : g_next
      assign src_res = res_q[k-1];
      assign src_cy  = cy_q[k-1];
      assign src_dec = dec_q[k-1];
      assign src_sat = sat_q[k-1];
      assign load[k] = adv[k-1];
    end

    one_adder_seg #(.W(W)) u_seg (
      .seg     (src_res[HI:LO]),
      .c_in    (src_cy),
      .dec     (src_dec),
      .seg_out (seg_out),
      .c_out   (c_out)
    );

    // Only this stage's segment changes; higher bits ride along unresolved.
    always_comb begin
      nxt        = src_res;
      nxt[HI:LO] = seg_out;
    end

    assign res_d[k] = nxt;
    assign cy_d[k]  = c_out;
    assign dec_d[k] = src_dec;
    assign sat_d[k] = src_sat;

    // A stage is blocked only if every slot below it is full and the sink stalls,
    // which is the unrolled form of "downstream empty or advancing".
    if (k == LAST) begin : g_adv_last
      assign adv[k] = vld_q[k] && bus.out_ready;
    end else begin : g_adv_mid
      assign adv[k] = vld_q[k] && (bus.out_ready || !(&vld_q[LAST:k+1]));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      cy_q  <= '0;
      dec_q <= '0;
      sat_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        res_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          vld_q[k] <= 1'b1;
          res_q[k] <= res_d[k];
          cy_q[k]  <= cy_d[k];
          dec_q[k] <= dec_d[k];
          sat_q[k] <= sat_d[k];
        end else if (adv[k]) begin
          vld_q[k] <= 1'b0;
        end
      end
    end
  end

  // Saturation is applied at the final stage output, once the full carry is known.
  // cout still reports the wrap when the result is clamped.
  assign bus.out_valid = vld_q[LAST];
  assign bus.cout      = cy_q[LAST];
  assign bus.SUM       = (sat_q[LAST] && cy_q[LAST]) ?
                         ((dec_q[LAST] == MODE_DEC) ? '0 : '1) : res_q[LAST];

endmodule

// File: tb/tb_pipelined_one_adder.sv
module tb_pipelined_one_adder;
  import arith_pkg::*;

  logic clk = 1'b0;
  logic rst0;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rnd_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operand.
  function automatic logic [32:0] golden(input int n, input logic [31:0] a,
                                         input logic c, input logic d, input logic s);
    longint m;
    longint t;
    longint r;
    logic   co;
    m = (longint'(1) << n) - 1;
    if (d == MODE_DEC) t = longint'(a) - longint'(c);
    else               t = longint'(a) + longint'(c);
    co = (t < 0) || (t > m);
    r  = t & m;
    if (s && co) r = (d == MODE_DEC) ? 0 : m;
    return {co, r[31:0]};
  endfunction

  // ---------------- directed DUT: N=8, SEG_W=4, STAGES=2 ----------------
  pipelined_one_adder_if #(.N(8)) d_if ();
  pipelined_one_adder #(.N(8), .SEG_W(4)) u_dut0 (
    .clk   (clk),
    .reset (rst0),
    .bus   (d_if)
  );

  typedef struct {
    string      name;
    logic [7:0] a;
    logic       cin;
    logic       dec;
    logic       sat;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  function automatic vec_t mk(input string nm, input logic [7:0] a, input logic c,
                              input logic d, input logic s, input logic [7:0] es,
                              input logic ec);
    vec_t v;
    v.name = nm; v.a = a; v.cin = c; v.dec = d; v.sat = s;
    v.exp_sum = es; v.exp_cout = ec;
    return v;
  endfunction

  initial begin
    vec_t vt[$];
    int   nxt;
    int   got;
    logic seen;

    vt.push_back(mk("cross_seg",   8'h0F, 1'b1, 1'b0, 1'b0, 8'h10, 1'b0));
    vt.push_back(mk("wrap_inc",    8'hFF, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1));
    vt.push_back(mk("sat_inc",     8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1));
    vt.push_back(mk("wrap_dec",    8'h00, 1'b1, 1'b1, 1'b0, 8'hFF, 1'b1));
    vt.push_back(mk("sat_dec",     8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1));
    vt.push_back(mk("dec_borrow",  8'h10, 1'b1, 1'b1, 1'b0, 8'h0F, 1'b0));
    vt.push_back(mk("cin0_inc",    8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0));
    vt.push_back(mk("cin0_dec",    8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0));
    vt.push_back(mk("sat_no_wrap", 8'h7F, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0));
    vt.push_back(mk("dec_mid",     8'h80, 1'b1, 1'b1, 1'b0, 8'h7F, 1'b0));

    rst0 = 1'b1;
    d_if.in_valid = 1'b0; d_if.A = '0; d_if.cin = 1'b0; d_if.dec = 1'b0;
    d_if.sat = 1'b0; d_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0;
    #1;
    chk("reset_out_valid", 64'(d_if.out_valid), 64'd0);
    chk("reset_in_ready",  64'(d_if.in_ready),  64'd1);
    chk("reset_sum",       64'(d_if.SUM),       64'd0);
    chk("reset_cout",      64'(d_if.cout),      64'd0);

    // Back-to-back stream; each result is due exactly 2 cycles after its accept.
    for (int i = 0; i < vt.size() + 2; i++) begin
      @(negedge clk);
      if (i < vt.size()) begin
        d_if.in_valid = 1'b1; d_if.A = vt[i].a; d_if.cin = vt[i].cin;
        d_if.dec = vt[i].dec; d_if.sat = vt[i].sat;
      end else begin
        d_if.in_valid = 1'b0;
      end
      d_if.out_ready = 1'b1;
      #1;
      if (i < vt.size()) chk("tbl_in_ready", 64'(d_if.in_ready), 64'd1);
      if (i >= 2) begin
        chk({vt[i-2].name, "_valid"}, 64'(d_if.out_valid), 64'd1);
        chk(vt[i-2].name, 64'({d_if.cout, d_if.SUM}), 64'({vt[i-2].exp_cout, vt[i-2].exp_sum}));
      end else begin
        chk("tbl_early_valid", 64'(d_if.out_valid), 64'd0);
      end
    end

    // Backpressure: A=1..6 streamed, sink stalls in cycles 3..5.
    nxt = 0; got = 0;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      d_if.in_valid  = (nxt < 6);
      d_if.A         = 8'(nxt + 1);
      d_if.cin       = 1'b1; d_if.dec = 1'b0; d_if.sat = 1'b0;
      d_if.out_ready = !(c >= 3 && c <= 5);
      #1;
      if (c == 1) chk("bp_in_ready_start", 64'(d_if.in_ready), 64'd1);
      if (c == 3) chk("bp_in_ready_full",  64'(d_if.in_ready), 64'd0);
      if (c >= 3 && c <= 5) begin
        chk("bp_hold_valid", 64'(d_if.out_valid), 64'd1);
        chk("bp_hold_sum",   64'(d_if.SUM),       64'h02);
      end
      if (d_if.out_valid) begin
        chk("bp_sum", 64'(d_if.SUM), 64'(got + 2));
        if (d_if.out_ready) got++;
      end
      if (d_if.in_valid && d_if.in_ready) nxt++;
    end
    chk("bp_results", 64'(got), 64'd6);
    chk("bp_accepted", 64'(nxt), 64'd6);

    // Reset with a beat in flight and another presented during the reset cycle.
    @(negedge clk);
    d_if.in_valid = 1'b1; d_if.A = 8'h3F; d_if.cin = 1'b1; d_if.dec = 1'b0;
    d_if.sat = 1'b0; d_if.out_ready = 1'b1;
    #1;
    chk("rst_accept", 64'(d_if.in_ready), 64'd1);
    @(negedge clk);
    d_if.A = 8'h55;
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    d_if.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(d_if.out_valid), 64'd0);
    chk("rst_sum",       64'(d_if.SUM),       64'd0);
    chk("rst_cout",      64'(d_if.cout),      64'd0);
    chk("rst_in_ready",  64'(d_if.in_ready),  64'd1);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (d_if.out_valid) seen = 1'b1;
    end
    chk("rst_no_ghost", 64'(seen), 64'd0);

    wait (rnd_done == 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // ---------------- random regression: (13,5) -> 3 stages, (8,8) -> 1 stage ----------------
  localparam int NUM = 300;

  for (genvar g = 0; g < 2; g++) begin : g_rnd
    localparam int NN = (g == 0) ? 13 : 8;
    localparam int SW = (g == 0) ? 5 : 8;
    localparam int ST = stages_f(NN, SW);

    logic rst_r;
    pipelined_one_adder_if #(.N(NN)) r_if ();
    pipelined_one_adder #(.N(NN), .SEG_W(SW)) u_dut (
      .clk   (clk),
      .reset (rst_r),
      .bus   (r_if)
    );

    initial begin
      logic [32:0] exp_q[$];
      int          acc_q[$];
      logic [32:0] e;
      logic [31:0] a;
      logic [31:0] mask;
      int          accepted;
      int          emitted;
      int          sw_cyc;
      int          acc_c;
      int          budget;
      logic        hold;

      mask = 32'((longint'(1) << NN) - 1);
      accepted = 0; emitted = 0; sw_cyc = -1; hold = 1'b0;
      rst_r = 1'b1;
      r_if.in_valid = 1'b0; r_if.A = '0; r_if.cin = 1'b0; r_if.dec = 1'b0;
      r_if.sat = 1'b0; r_if.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_r = 1'b0;

      for (budget = 0; budget < 5000 && emitted < NUM; budget++) begin
        @(negedge clk);
        if (!hold) begin
          if (accepted < NUM && $urandom_range(0, 3) != 0) begin
            case ($urandom_range(0, 3))
              0:       a = 32'd0;
              1:       a = mask;
              default: a = $urandom & mask;
            endcase
            r_if.in_valid = 1'b1;
            r_if.A        = a[NN-1:0];
            r_if.cin      = ($urandom_range(0, 3) != 0);
            r_if.dec      = 1'($urandom_range(0, 1));
            r_if.sat      = 1'($urandom_range(0, 1));
          end else begin
            r_if.in_valid = 1'b0;
          end
        end
        if (accepted >= NUM / 2 && sw_cyc < 0) sw_cyc = cyc;
        r_if.out_ready = (sw_cyc >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        #1;
        if (r_if.out_valid && r_if.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("rnd_unexpected_beat", 64'd1, 64'd0);
          end else begin
            e     = exp_q.pop_front();
            acc_c = acc_q.pop_front();
            chk("rnd_result", 64'({r_if.cout, 32'(r_if.SUM)}), 64'(e));
            if (sw_cyc >= 0 && acc_c >= sw_cyc)
              chk("rnd_latency_exact", 64'(cyc - acc_c), 64'(ST));
            else
              chk("rnd_latency_min", 64'((cyc - acc_c) >= ST), 64'd1);
          end
          emitted++;
        end
        if (r_if.in_valid && r_if.in_ready) begin
          exp_q.push_back(golden(NN, 32'(r_if.A), r_if.cin, r_if.dec, r_if.sat));
          acc_q.push_back(cyc);
          accepted++;
          hold = 1'b0;
        end else begin
          hold = r_if.in_valid;
        end
      end
      chk("rnd_all_emitted", 64'(emitted), 64'(NUM));
      chk("rnd_queue_empty", 64'(exp_q.size()), 64'd0);
      r_if.in_valid = 1'b0;
      rnd_done++;
    end
  end

endmodule
